motoro3_line_calc_param_seq: RTL and testbench

- Sequential, parametrised successor to the combinational line-parameter calculator.
- Takes a PWM length range (pwmMin..pwmLen) and a step count, computes a fixed-point slope with an iterative divider, then streams one PWM value per step over a valid/ready interface.
- Ramp direction is selectable (up or down).
- Sits between the motor configuration registers and the PWM/sine step tables of the 3-phase drive.

---
 rtl/motoro3_lc_pkg.sv | 17 +
 rtl/motoro3_seq_divider.sv | 59 +++++
 rtl/motoro3_line_calc_param_seq.sv | 131 +++++++++++++
 tb/tb_motoro3_line_calc_param_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_lc_pkg.sv
// rtl/motoro3_lc_pkg.sv - shared types and default widths for the line-parameter sequencer
package motoro3_lc_pkg;

   localparam int LC_PWM_W  = 8;
   localparam int LC_STEP_W = 4;
   localparam int LC_FRAC_W = 8;
   localparam int LC_ACC_W  = LC_PWM_W + LC_FRAC_W + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      DIV   = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } lc_state_t;

endpackage

// File: rtl/motoro3_seq_divider.sv
// rtl/motoro3_seq_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
module motoro3_seq_divider #(
   parameter int NUM_W = 16,
   parameter int DEN_W = 4
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             done,
   output logic [NUM_W-1:0] quot
);

   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] q;
   logic [DEN_W-1:0] rem;
   logic [CNT_W-1:0] cnt;
   logic             running;
   logic [DEN_W:0]   trial;
   logic [DEN_W:0]   sub;
   logic             fits;

   // q shifts the numerator out of its MSB while quotient bits enter at the LSB.
   // The remainder stays below den, so a borrow in the top bit of sub means "does not fit".
   always_comb begin
      trial = {rem, q[NUM_W-1]};
      sub   = trial - {1'b0, den};
      fits  = ~sub[DEN_W];
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         q       <= '0;
         rem     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         q       <= num;
         rem     <= '0;
         cnt     <= CNT_W'(NUM_W);
         running <= 1'b1;
         done    <= 1'b0;
      end else if (running) begin
         q   <= {q[NUM_W-2:0], fits};
         rem <= fits ? sub[DEN_W-1:0] : trial[DEN_W-1:0];
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            running <= 1'b0;
            done    <= 1'b1;
         end
      end
   end

   assign quot = q;

endmodule

// File: rtl/motoro3_line_calc_param_seq.sv
// rtl/motoro3_line_calc_param_seq.sv - sequential ramp generator streaming one PWM value per step
module motoro3_line_calc_param_seq
   import motoro3_lc_pkg::*;
#(
   parameter int PWM_W  = LC_PWM_W,
   parameter int STEP_W = LC_STEP_W,
   parameter int FRAC_W = LC_FRAC_W
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              start,
   input  logic [PWM_W-1:0]  pwmLen,
   input  logic [PWM_W-1:0]  pwmMin,
   input  logic [STEP_W-1:0] lcStepNum,
   input  logic              lcDir,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              outValid,
   input  logic              outReady,
   output logic [STEP_W-1:0] outIdx,
   output logic [PWM_W-1:0]  outVal
);

   localparam int QUO_W = PWM_W + FRAC_W;
   localparam int ACC_W = PWM_W + FRAC_W + 1;

   lc_state_t         state, next_state;
   logic [PWM_W-1:0]  len_r, min_r;
   logic [STEP_W-1:0] n_r;
   logic              dir_r;
   logic [ACC_W-1:0]  acc, acc_next;
   logic [QUO_W-1:0]  slope;
   logic [PWM_W-1:0]  span;
   logic [STEP_W-1:0] idx_inc;
   logic [PWM_W-1:0]  end_val;
   logic              bad, div_start, div_done, xfer, last_xfer;

   motoro3_seq_divider #(
      .NUM_W(QUO_W),
      .DEN_W(STEP_W)
   ) u_div (
      .clk  (clk),
      .nRst (nRst),
      .start(div_start),
      .num  ({span, {FRAC_W{1'b0}}}),
      .den  (n_r),
      .done (div_done),
      .quot (slope)
   );

   always_ff @(posedge clk) begin
      if (!nRst) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CHECK;
         CHECK:   next_state = bad ? DONE : DIV;
         DIV:     if (div_done) next_state = EMIT;
         EMIT:    if (last_xfer) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      bad       = (len_r < min_r) || (n_r == '0);
      span      = len_r - min_r;
      div_start = (state == CHECK) && !bad;
      xfer      = (state == EMIT) && outValid && outReady;
      last_xfer = xfer && (outIdx == n_r);
      idx_inc   = outIdx + STEP_W'(1);
      end_val   = dir_r ? min_r : len_r;
      acc_next  = dir_r ? (acc - ACC_W'(slope)) : (acc + ACC_W'(slope));
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         len_r    <= '0;
         min_r    <= '0;
         n_r      <= '0;
         dir_r    <= 1'b0;
         acc      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         outValid <= 1'b0;
         outIdx   <= '0;
         outVal   <= '0;
      end else begin
         // Registered so the pulse lines up with busy falling.
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  len_r <= pwmLen;
                  min_r <= pwmMin;
                  n_r   <= lcStepNum;
                  dir_r <= lcDir;
                  err   <= 1'b0;
               end
            end
            CHECK: err <= bad;
            DIV: begin
               if (div_done) begin
                  acc      <= dir_r ? {1'b0, len_r, {FRAC_W{1'b0}}}
                                    : {1'b0, min_r, {FRAC_W{1'b0}}};
                  outVal   <= dir_r ? len_r : min_r;
                  outIdx   <= '0;
                  outValid <= 1'b1;
               end
            end
            EMIT: begin
               if (last_xfer) begin
                  outValid <= 1'b0;
               end else if (xfer) begin
                  // The final entry is pinned to the endpoint to hide slope truncation.
                  acc    <= acc_next;
                  outIdx <= idx_inc;
                  outVal <= (idx_inc == n_r) ? end_val : acc_next[FRAC_W +: PWM_W];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_motoro3_line_calc_param_seq.sv
// tb/tb_motoro3_line_calc_param_seq.sv - scoreboard bench for the ramp sequencer
module tb_motoro3_line_calc_param_seq;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] pwmLen = '0;
   logic [7:0] pwmMin = '0;
   logic [3:0] lcStepNum = '0;
   logic       lcDir = 1'b0;
   logic       outReady = 1'b0;
   logic       busy, done, err, outValid;
   logic [3:0] outIdx;
   logic [7:0] outVal;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] idx;
      logic [7:0] val;
   } ent_t;

   ent_t exp_q[$];
   logic done_q[$];
   ent_t mon_e;

   always #5 clk = ~clk;

   motoro3_line_calc_param_seq dut (
      .clk      (clk),
      .nRst     (nRst),
      .start    (start),
      .pwmLen   (pwmLen),
      .pwmMin   (pwmMin),
      .lcStepNum(lcStepNum),
      .lcDir    (lcDir),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .outValid (outValid),
      .outReady (outReady),
      .outIdx   (outIdx),
      .outVal   (outVal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ramp: real-valued line sampled with a truncated 8-bit-fraction slope.
   function automatic void push_job(input int len, input int min, input int n, input int dir);
      int slope, v;
      ent_t e;
      if (len < min || n == 0) begin
         done_q.push_back(1'b1);
         return;
      end
      slope = ((len - min) * 256) / n;
      for (int i = 0; i <= n; i++) begin
         if (i == n) v = dir ? min : len;
         else if (dir) v = (len * 256 - i * slope) / 256;
         else v = (min * 256 + i * slope) / 256;
         e.idx = 4'(i);
         e.val = 8'(v);
         exp_q.push_back(e);
      end
      done_q.push_back(1'b0);
   endfunction

   always @(negedge clk) begin
      if (nRst === 1'b1) begin
         if (outValid && outReady) begin
            if (exp_q.size() == 0) chk("unexpected_entry", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("entry_idx", 32'(outIdx), 32'(mon_e.idx));
               chk("entry_val", 32'(outVal), 32'(mon_e.val));
            end
         end
         if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_err", 32'(err), 32'(done_q.pop_front()));
         end
      end
   end

   // mode: 0 always ready, 1 random ready and stray starts, 2 stall at idx 2, 3 reset at idx 5
   task automatic run_job(input int len, input int min, input int n, input int dir, input int mode);
      int  k, stall;
      bit  seen_v, pend, will, bogus, finished, bad;
      bad = (len < min) || (n == 0);
      push_job(len, min, n, dir);
      pwmLen = 8'(len);
      pwmMin = 8'(min);
      lcStepNum = 4'(n);
      lcDir = (dir != 0);
      outReady = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pwmLen = 8'($urandom);
      pwmMin = 8'($urandom);
      lcStepNum = 4'($urandom);
      lcDir = 1'($urandom);
      chk("busy_after_start", 32'(busy), 1);
      if (bad) begin
         k = 0;
         seen_v = 1'b0;
         while (k < 10) begin
            @(posedge clk); #1;
            k++;
            if (outValid) seen_v = 1'b1;
            if (done) break;
         end
         chk("err_done_latency", k, 2);
         chk("err_no_valid", 32'(seen_v), 0);
         chk("err_flag", 32'(err), 1);
         return;
      end
      k = 0;
      while (k < 60) begin
         @(posedge clk); #1;
         k++;
         if (outValid) break;
      end
      chk("first_valid_latency", k, 18);
      k = 0;
      stall = 0;
      pend = 1'b0;
      bogus = 1'b0;
      finished = 1'b0;
      while (k < 500 && !finished) begin
         if (mode == 3 && outValid && outIdx == 4'd5) begin
            nRst = 1'b0;
            @(posedge clk); #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_valid", 32'(outValid), 0);
            chk("rst_idx", 32'(outIdx), 0);
            chk("rst_val", 32'(outVal), 0);
            nRst = 1'b1;
            exp_q.delete();
            done_q.delete();
            return;
         end
         if (mode == 1) outReady = ($urandom_range(0, 3) != 0);
         else if (mode == 2 && outValid && outIdx == 4'd2 && stall < 3) begin
            outReady = 1'b0;
            stall++;
            chk("stall_idx", 32'(outIdx), 2);
            if (exp_q.size() > 0) chk("stall_val", 32'(outVal), 32'(exp_q[0].val));
         end else outReady = 1'b1;
         if (outValid && !bogus &&
             ((mode == 2 && outIdx == 4'd1) || (mode == 1 && $urandom_range(0, 7) == 0))) begin
            start = 1'b1;
            bogus = 1'b1;
         end else start = 1'b0;
         will = outValid && outReady && (outIdx == 4'(n));
         @(posedge clk); #1;
         k++;
         if (pend) begin
            chk("done_after_last", 32'(done), 1);
            chk("busy_low_at_done", 32'(busy), 0);
            finished = 1'b1;
         end
         pend = will;
      end
      start = 1'b0;
      if (!finished) chk("job_timeout", 0, 1);
      if (mode == 2) chk("stall_cycles", stall, 3);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_valid", 32'(outValid), 0);
      chk("reset_idx", 32'(outIdx), 0);
      chk("reset_val", 32'(outVal), 0);
      nRst = 1'b1;
      @(posedge clk); #1;

      run_job(200, 40, 4, 0, 0);
      run_job(100, 0, 3, 0, 0);
      run_job(200, 40, 4, 1, 0);
      run_job(30, 50, 2, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("err_held", 32'(err), 1);
      run_job(200, 40, 4, 0, 2);
      chk("err_cleared", 32'(err), 0);
      run_job(77, 77, 15, 0, 0);
      run_job(77, 77, 15, 0, 3);
      run_job(77, 77, 15, 1, 0);
      run_job(100, 100, 0, 0, 0);

      repeat (16) begin
         int len, min, n, dir, mode;
         len = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) min = $urandom_range(0, len);
         else min = $urandom_range(0, 255);
         n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
         dir = $urandom_range(0, 1);
         mode = $urandom_range(0, 1);
         run_job(len, min, n, dir, mode);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
